tsp_path_tx: RTL and testbench

- Streams a snapshot of the solver's current tour to the host side as a framed byte stream. This is the read/transmit end of the solver's `path` output.
- On `start`, latches the `path` array and walks it vertex by vertex, emitting (vertex, x, y) records.
- While streaming, accumulates the Manhattan tour length and checks that the tour is a valid permutation.
- Sits between `tsp` (path, xs, ys) and the board's UART/host byte sink.

---
 rtl/tsp_pkg.sv | 28 ++
 rtl/manhattan_dist.sv | 17 +
 rtl/tsp_path_tx.sv | 197 +++++++++++++++++++
 tb/tb_tsp_path_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
// Shared types and constants for the TSP solver path transmitter and its helpers.
package tsp_pkg;

    localparam int N_VERT    = 64;
    localparam int IDX_W     = $clog2(N_VERT);
    localparam int COORD_W   = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_LEN = 1 + 3 * N_VERT + 4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_STAT,
        ST_CSUM,
        ST_DONE
    } tx_state_e;

    function automatic logic [7:0] idx_byte(input idx_t idx);
        return {{(8 - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/manhattan_dist.sv
// Combinational Manhattan distance between two 8-bit (x,y) points; 9-bit result.
module manhattan_dist (
    input  logic [7:0] x_a_i,
    input  logic [7:0] y_a_i,
    input  logic [7:0] x_b_i,
    input  logic [7:0] y_b_i,
    output logic [8:0] dist_o
);

    logic [7:0] dx;
    logic [7:0] dy;

    assign dx     = (x_a_i >= x_b_i) ? (x_a_i - x_b_i) : (x_b_i - x_a_i);
    assign dy     = (y_a_i >= y_b_i) ? (y_a_i - y_b_i) : (y_b_i - y_a_i);
    assign dist_o = {1'b0, dx} + {1'b0, dy};

endmodule

// File: rtl/tsp_path_tx.sv
// Streams a snapshot of the solver tour as a framed byte stream, while summing the
// closed-tour Manhattan length and checking that the snapshot is a permutation.
module tsp_path_tx
    import tsp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [COORD_W*N_VERT-1:0]   xs,
    input  logic [COORD_W*N_VERT-1:0]   ys,
    input  logic [IDX_W*N_VERT-1:0]     path,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        perm_ok,
    output logic [15:0]                 tour_len,
    output logic [2:0]                  dbg_state
);

    // Handshake: a byte moves when tx_valid && tx_ready at a rising clk edge.
    // tx_data/tx_valid are registers; they only change on a transfer, at start,
    // or on reset, so the offered byte is stable for the whole stall.

    tx_state_e                  state_q;
    logic [IDX_W*N_VERT-1:0]    snap_q;
    logic [N_VERT-1:0]          seen_q;
    logic                       dup_q;
    logic [15:0]                acc_q;
    logic [7:0]                 csum_q;
    idx_t                       k_q;
    logic [1:0]                 f_q;
    logic [7:0]                 tx_data_q;
    logic                       tx_valid_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       perm_ok_q;
    logic [15:0]                tour_len_q;

    logic       xfer;
    idx_t       k_nxt;
    idx_t       cur_idx;
    idx_t       nxt_idx;
    coord_t     cur_x;
    coord_t     cur_y;
    coord_t     nxt_x;
    coord_t     nxt_y;
    logic [8:0] edge_d;
    logic [15:0] acc_d;
    logic [7:0] csum_d;

    assign xfer    = tx_valid_q && tx_ready;
    assign k_nxt   = k_q + 1'b1;
    assign cur_idx = snap_q[IDX_W*k_q +: IDX_W];
    assign nxt_idx = snap_q[IDX_W*k_nxt +: IDX_W];
    assign cur_x   = xs[COORD_W*cur_idx +: COORD_W];
    assign cur_y   = ys[COORD_W*cur_idx +: COORD_W];
    assign nxt_x   = xs[COORD_W*nxt_idx +: COORD_W];
    assign nxt_y   = ys[COORD_W*nxt_idx +: COORD_W];
    assign acc_d   = acc_q + {7'b0, edge_d};
    assign csum_d  = csum_q ^ tx_data_q;

    // k_nxt wraps 63 -> 0, so the last record closes the tour back to p_0.
    manhattan_dist u_dist (
        .x_a_i  (cur_x),
        .y_a_i  (cur_y),
        .x_b_i  (nxt_x),
        .y_b_i  (nxt_y),
        .dist_o (edge_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            seen_q     <= '0;
            dup_q      <= 1'b0;
            acc_q      <= '0;
            csum_q     <= '0;
            k_q        <= '0;
            f_q        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perm_ok_q  <= 1'b0;
            tour_len_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snap_q     <= path;
                        seen_q     <= '0;
                        dup_q      <= 1'b0;
                        acc_q      <= '0;
                        csum_q     <= '0;
                        k_q        <= '0;
                        f_q        <= '0;
                        tour_len_q <= '0;
                        perm_ok_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                        state_q    <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (xfer) begin
                        csum_q    <= csum_d;
                        tx_data_q <= idx_byte(cur_idx);
                        state_q   <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (xfer) begin
                        csum_q <= csum_d;
                        case (f_q)
                            2'd0: begin
                                if (seen_q[cur_idx]) begin
                                    dup_q <= 1'b1;
                                end
                                seen_q[cur_idx] <= 1'b1;
                                f_q             <= 2'd1;
                                tx_data_q       <= cur_x;
                            end
                            2'd1: begin
                                f_q       <= 2'd2;
                                tx_data_q <= cur_y;
                            end
                            default: begin
                                acc_q <= acc_d;
                                f_q   <= 2'd0;
                                k_q   <= k_nxt;
                                if (k_q == idx_t'(N_VERT - 1)) begin
                                    tour_len_q <= acc_d;
                                    tx_data_q  <= acc_d[15:8];
                                    state_q    <= ST_LEN_HI;
                                end else begin
                                    tx_data_q  <= idx_byte(nxt_idx);
                                end
                            end
                        endcase
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        csum_q    <= csum_d;
                        tx_data_q <= tour_len_q[7:0];
                        state_q   <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        csum_q    <= csum_d;
                        perm_ok_q <= ~dup_q;
                        tx_data_q <= {7'b0, ~dup_q};
                        state_q   <= ST_STAT;
                    end
                end
                ST_STAT: begin
                    // The checksum byte folds in the status byte being sent now.
                    if (xfer) begin
                        csum_q    <= csum_d;
                        tx_data_q <= csum_d;
                        state_q   <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign perm_ok   = perm_ok_q;
    assign tour_len  = tour_len_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tsp_path_tx.sv
// Directed bench for tsp_path_tx: table of tour patterns with hand-computed trailers,
// plus sequences for restart-while-busy and reset mid-frame.
module tb_tsp_path_tx;
    import tsp_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       tx_ready;
    logic [8*N_VERT-1:0]        xs;
    logic [8*N_VERT-1:0]        ys;
    logic [6*N_VERT-1:0]        path;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       busy;
    logic                       done;
    logic                       perm_ok;
    logic [15:0]                tour_len;
    logic [2:0]                 dbg_state;

    logic [7:0] x_arr [N_VERT];
    logic [7:0] y_arr [N_VERT];
    logic [5:0] p_arr [N_VERT];

    genvar gi;
    generate
        for (gi = 0; gi < N_VERT; gi++) begin : g_pack
            assign xs[8*gi +: 8]   = x_arr[gi];
            assign ys[8*gi +: 8]   = y_arr[gi];
            assign path[6*gi +: 6] = p_arr[gi];
        end
    endgenerate

    always #5 clk = ~clk;

    tsp_path_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .xs        (xs),
        .ys        (ys),
        .path      (path),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .perm_ok   (perm_ok),
        .tour_len  (tour_len),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        int          pat;
        logic [15:0] len;
        logic        perm;
        logic [7:0]  csum;
        bit          rnd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < N_VERT; i++) begin
            p_arr[i] = 6'(i);
            x_arr[i] = 8'(i);
            y_arr[i] = 8'h00;
            case (pat)
                1: x_arr[i] = 8'h00;
                2: if (i == 5) p_arr[i] = 6'd6;
                3: begin
                    p_arr[i] = 6'(63 - i);
                    y_arr[i] = 8'(2 * i);
                end
                4: x_arr[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
                default: ;
            endcase
        end
    endtask

    // Body bytes come straight from the arrays; the trailer comes from the table.
    task automatic build_expected(input logic [15:0] len, input logic perm, input logic [7:0] csum);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < N_VERT; k++) begin
            exp_q.push_back({2'b00, p_arr[k]});
            exp_q.push_back(x_arr[p_arr[k]]);
            exp_q.push_back(y_arr[p_arr[k]]);
        end
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        exp_q.push_back({7'b0, perm});
        exp_q.push_back(csum);
    endtask

    // action 0: plain, 1: path poke at byte 30 and start pulse at byte 50, 2: reset at byte 100
    task automatic run_frame(input string tag, input bit rnd, input int action,
                             output int n_bytes, output int lat);
        int         cyc;
        int         nb;
        bit         stalled;
        bit         got_done;
        bit         poked;
        logic [7:0] held;
        logic [7:0] d;
        logic       v;
        cyc = 0; nb = 0; stalled = 0; got_done = 0; poked = 0; held = '0; lat = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("%s busy_after_start", tag), busy, 1);
        check($sformatf("%s valid_after_start", tag), tx_valid, 1);
        while (cyc < 2000 && !got_done) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            v = tx_valid;
            d = tx_data;
            if (stalled && v) check($sformatf("%s stall_hold b%0d", tag, nb), d, held);
            if (action == 1 && nb >= 30 && !poked) begin
                p_arr[3] = p_arr[3] + 6'd1;
                poked = 1;
            end
            start = (action == 1 && nb == 50) ? 1'b1 : 1'b0;
            if (action == 2 && nb == 100) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s rst_valid", tag), tx_valid, 0);
                check($sformatf("%s rst_busy", tag), busy, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                tx_ready = 1'b1;
                n_bytes = nb;
                return;
            end
            @(posedge clk); #1;
            cyc++;
            if (v && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s extra_byte b%0d", tag, nb), d, 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("%s byte b%0d", tag, nb), d, exp_q.pop_front());
                end
                nb++;
            end
            stalled = v && !tx_ready;
            held = d;
            if (done) begin
                got_done = 1;
                lat = cyc;
            end
        end
        start = 1'b0;
        tx_ready = 1'b1;
        if (!got_done) check($sformatf("%s done_timeout", tag), 0, 1);
        n_bytes = nb;
    endtask

    task automatic end_of_frame(input string tag, input int nb, input vec_t vc);
        check($sformatf("%s byte_count", tag), nb, FRAME_LEN);
        check($sformatf("%s exp_left", tag), exp_q.size(), 0);
        check($sformatf("%s tour_len", tag), tour_len, vc.len);
        check($sformatf("%s perm_ok", tag), perm_ok, vc.perm);
        check($sformatf("%s busy_at_done", tag), busy, 0);
        check($sformatf("%s valid_at_done", tag), tx_valid, 0);
        @(posedge clk); #1;
        check($sformatf("%s done_pulse_len", tag), done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   nb;
        int   lat;
        vec_t vc;

        vecs[0] = '{pat: 0, len: 16'h007E, perm: 1'b1, csum: 8'hDA, rnd: 1'b0};
        vecs[1] = '{pat: 1, len: 16'h0000, perm: 1'b1, csum: 8'hA4, rnd: 1'b0};
        vecs[2] = '{pat: 2, len: 16'h007E, perm: 1'b0, csum: 8'hDB, rnd: 1'b0};
        vecs[3] = '{pat: 3, len: 16'h017A, perm: 1'b1, csum: 8'hDF, rnd: 1'b0};
        vecs[4] = '{pat: 4, len: 16'h3FC0, perm: 1'b1, csum: 8'h5B, rnd: 1'b0};
        vecs[5] = '{pat: 0, len: 16'h007E, perm: 1'b1, csum: 8'hDA, rnd: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        load_pattern(0);
        #1;
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_data", tx_data, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset perm_ok", perm_ok, 0);
        check("reset tour_len", tour_len, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            vc = vecs[i];
            load_pattern(vc.pat);
            build_expected(vc.len, vc.perm, vc.csum);
            run_frame($sformatf("vec%0d", i), vc.rnd, 0, nb, lat);
            if (!vc.rnd) check($sformatf("vec%0d done_latency", i), lat, FRAME_LEN);
            end_of_frame($sformatf("vec%0d", i), nb, vc);
        end

        // Second start mid-frame plus path change: both must be ignored.
        vc = vecs[0];
        load_pattern(0);
        build_expected(vc.len, vc.perm, vc.csum);
        run_frame("restart", 1'b0, 1, nb, lat);
        end_of_frame("restart", nb, vc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("restart idle_done c%0d", i), done, 0);
            check($sformatf("restart idle_busy c%0d", i), busy, 0);
        end
        load_pattern(0);
        build_expected(vc.len, vc.perm, vc.csum);
        run_frame("second", 1'b0, 0, nb, lat);
        end_of_frame("second", nb, vc);

        // Reset at byte 100, then a clean frame.
        load_pattern(0);
        build_expected(vc.len, vc.perm, vc.csum);
        run_frame("abort", 1'b0, 2, nb, lat);
        check("abort bytes_before_rst", nb, 100);
        @(posedge clk); #1;
        check("abort idle_valid", tx_valid, 0);
        check("abort idle_done", done, 0);
        build_expected(vc.len, vc.perm, vc.csum);
        run_frame("after_rst", 1'b0, 0, nb, lat);
        check("after_rst done_latency", lat, FRAME_LEN);
        end_of_frame("after_rst", nb, vc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
